// File: rtl/exec_div_unit_if.sv
// Divider bus between the execute stage (master) and exec_div_unit (slave).
// Carries the start/operand request, the kill request and the busy/done/result response.
interface exec_div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            div_start;
  logic [1:0]      div_op;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic            div_kill;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  // Execute stage side: issues requests, observes status.
  modport master (
    output div_start, div_op, div_a, div_b, div_kill,
    input  div_busy, div_done, div_result
  );

  // Divider side: accepts requests, reports status and result.
  modport slave (
    input  div_start, div_op, div_a, div_b, div_kill,
    output div_busy, div_done, div_result
  );
endinterface

// File: rtl/exec_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// FSM: IDLE -> SETUP -> ITER (32 steps) -> FIX -> IDLE. The special cases
// (divide by zero, signed overflow) go SETUP -> FIX with a precomputed result.
// Optional macro DIV_RESULT_CACHE_EN: remembers the last completed operands and
// results so a matching start (e.g. REM after DIV) goes straight to FIX.
module exec_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  exec_div_unit_if.slave   div_if
);

  localparam int unsigned W  = XLEN;
  localparam int unsigned CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_ITER  = 2'd2,
    S_FIX   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;

`ifdef DIV_RESULT_CACHE_EN
  logic           c_vld_q, c_vld_d;
  logic [W-1:0]   c_a_q, c_a_d;
  logic [W-1:0]   c_b_q, c_b_d;
  logic           c_sgn_q, c_sgn_d;
  logic [W-1:0]   c_quo_q, c_quo_d;
  logic [W-1:0]   c_rem_q, c_rem_d;
  logic           hit_c;
`endif

  // Signed-op decode: op[0]==0 selects DIV/REM.
  logic           sgn_q_c;
  logic           sgn_in_c;
  logic [W-1:0]   a_abs_c;
  logic [W-1:0]   b_abs_c;
  logic [W:0]     rem_sh_c;
  logic [W:0]     rem_sub_c;
  logic [W-1:0]   quo_fix_c;
  logic [W-1:0]   rem_fix_c;

  assign sgn_q_c  = ~op_q[0];
  assign sgn_in_c = ~div_if.div_op[0];

  // Operand magnitudes used in SETUP.
  assign a_abs_c = (sgn_q_c && a_q[W-1]) ? -a_q : a_q;
  assign b_abs_c = (sgn_q_c && b_q[W-1]) ? -b_q : b_q;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign rem_sh_c  = {rem_q, quo_q[W-1]};
  assign rem_sub_c = rem_sh_c - {1'b0, dvs_q};

  // Sign post-correction applied in FIX.
  assign quo_fix_c = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix_c = neg_rem_q ? -rem_q : rem_q;

`ifdef DIV_RESULT_CACHE_EN
  // Cache lookup against the incoming request.
  assign hit_c = c_vld_q && (div_if.div_a == c_a_q) && (div_if.div_b == c_b_q)
                 && (sgn_in_c == c_sgn_q);
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    result_d  = result_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`ifdef DIV_RESULT_CACHE_EN
    c_vld_d   = c_vld_q;
    c_a_d     = c_a_q;
    c_b_d     = c_b_q;
    c_sgn_d   = c_sgn_q;
    c_quo_d   = c_quo_q;
    c_rem_d   = c_rem_q;
    if (div_if.div_kill) begin
      c_vld_d = 1'b0;
    end
`endif

    if (state_q != S_IDLE && div_if.div_kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (div_if.div_start && !div_if.div_kill) begin
            op_d = div_if.div_op;
            a_d  = div_if.div_a;
            b_d  = div_if.div_b;
`ifdef DIV_RESULT_CACHE_EN
            if (hit_c) begin
              quo_d     = c_quo_q;
              rem_d     = c_rem_q;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_FIX;
            end else begin
              state_d = S_SETUP;
            end
`else
            state_d = S_SETUP;
`endif
          end
        end

        S_SETUP: begin
          if (b_q == '0) begin
            quo_d     = '1;
            rem_d     = a_q;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIX;
          end else if (sgn_q_c && a_q == MIN_NEG && b_q == '1) begin
            quo_d     = MIN_NEG;
            rem_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIX;
          end else begin
            quo_d     = a_abs_c;
            rem_d     = '0;
            dvs_d     = b_abs_c;
            neg_quo_d = sgn_q_c & (a_q[W-1] ^ b_q[W-1]);
            neg_rem_d = sgn_q_c & a_q[W-1];
            cnt_d     = '0;
            state_d   = S_ITER;
          end
        end

        S_ITER: begin
          if (!rem_sub_c[W]) begin
            rem_d = W'(rem_sub_c);
            quo_d = {quo_q[W-2:0], 1'b1};
          end else begin
            rem_d = W'(rem_sh_c);
            quo_d = {quo_q[W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_d = S_FIX;
          end
        end

        S_FIX: begin
          result_d = op_q[1] ? rem_fix_c : quo_fix_c;
          done_d   = 1'b1;
          state_d  = S_IDLE;
`ifdef DIV_RESULT_CACHE_EN
          c_vld_d  = 1'b1;
          c_a_d    = a_q;
          c_b_d    = b_q;
          c_sgn_d  = sgn_q_c;
          c_quo_d  = quo_fix_c;
          c_rem_d  = rem_fix_c;
`endif
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  // Last-result cache registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_vld_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_sgn_q <= 1'b0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else begin
      c_vld_q <= c_vld_d;
      c_a_q   <= c_a_d;
      c_b_q   <= c_b_d;
      c_sgn_q <= c_sgn_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
    end
  end
`endif

  assign div_if.div_busy   = busy_q;
  assign div_if.div_done   = done_q;
  assign div_if.div_result = result_q;

endmodule

// File: tb/tb_exec_div_unit.sv
// Directed bench for exec_div_unit: results, latencies, special cases, kill,
// ignored starts, optional result cache and asynchronous reset.
module tb_exec_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT      = 1;
  localparam int HIT_SPEC_LAT = 1;
`else
  localparam int HIT_LAT      = 34;
  localparam int HIT_SPEC_LAT = 2;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  exec_div_unit_if #(.XLEN(32)) dif();

  exec_div_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .div_if  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op (caller is just after a posedge); returns done latency and result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    dif.div_start = 1'b1;
    dif.div_op    = op;
    dif.div_a     = a;
    dif.div_b     = b;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (dif.div_done) begin
        lat = i;
        break;
      end
    end
    res = dif.div_result;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dif.div_busy !== 1'b0 || dif.div_done !== 1'b0 || dif.div_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b result=%h expected 0/0/00000000",
               dif.div_busy, dif.div_done, dif.div_result);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu();
    int          lat;
    logic [31:0] res;
    int          done_cnt;
    // First op stepped manually to watch busy and the done pulse shape.
    dif.div_start = 1'b1;
    dif.div_op    = OP_DIVU;
    dif.div_a     = 32'd100;
    dif.div_b     = 32'd7;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    checks++;
    if (dif.div_busy !== 1'b1) begin
      errors++;
      $display("FAIL divu_busy_at_e0 busy=%b expected 1", dif.div_busy);
    end
    done_cnt = 0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (dif.div_done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 34 || dif.div_result !== 32'd14) begin
      errors++;
      $display("FAIL divu_100_7 latency=%0d result=%h expected 34/0000000e", lat, dif.div_result);
    end
    checks++;
    if (dif.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL divu_busy_at_done busy=%b expected 0", dif.div_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (dif.div_done !== 1'b0 || dif.div_result !== 32'd14) begin
      errors++;
      $display("FAIL divu_done_pulse done=%b result=%h expected 0/0000000e", dif.div_done, dif.div_result);
    end
    run_op(OP_REMU, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== HIT_LAT || res !== 32'd2) begin
      errors++;
      $display("FAIL remu_100_7 latency=%0d result=%h expected %0d/00000002", lat, res, HIT_LAT);
    end
  endtask

  task automatic test_signed();
    int          lat;
    logic [31:0] res;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_m7_2 latency=%0d result=%h expected 34/fffffffd", lat, res);
    end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res);
    checks++;
    if (lat !== HIT_LAT || res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rem_m7_2 latency=%0d result=%h expected %0d/ffffffff", lat, res, HIT_LAT);
    end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'd1) begin
      errors++;
      $display("FAIL rem_7_m2 latency=%0d result=%h expected 34/00000001", lat, res);
    end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'd3) begin
      errors++;
      $display("FAIL div_m7_m2 latency=%0d result=%h expected 34/00000003", lat, res);
    end
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'h7FFF_FFFC) begin
      errors++;
      $display("FAIL divu_big_2 latency=%0d result=%h expected 34/7ffffffc", lat, res);
    end
  endtask

  task automatic test_div_by_zero();
    int          lat;
    logic [31:0] res;
    run_op(OP_DIV, 32'd5, 32'd0, lat, res);
    checks++;
    if (lat !== 2 || res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_5_0 latency=%0d result=%h expected 2/ffffffff", lat, res);
    end
    run_op(OP_REMU, 32'h1234, 32'd0, lat, res);
    checks++;
    if (lat !== 2 || res !== 32'h1234) begin
      errors++;
      $display("FAIL remu_1234_0 latency=%0d result=%h expected 2/00001234", lat, res);
    end
    run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, lat, res);
    checks++;
    if (lat !== 2 || res !== 32'hFFFF_FFFB) begin
      errors++;
      $display("FAIL rem_m5_0 latency=%0d result=%h expected 2/fffffffb", lat, res);
    end
  endtask

  task automatic test_overflow();
    int          lat;
    logic [31:0] res;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    checks++;
    if (lat !== 2 || res !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_min_m1 latency=%0d result=%h expected 2/80000000", lat, res);
    end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    checks++;
    if (lat !== HIT_SPEC_LAT || res !== 32'h0) begin
      errors++;
      $display("FAIL rem_min_m1 latency=%0d result=%h expected %0d/00000000", lat, res, HIT_SPEC_LAT);
    end
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'h0) begin
      errors++;
      $display("FAIL divu_min_ffff latency=%0d result=%h expected 34/00000000", lat, res);
    end
  endtask

  task automatic test_kill();
    int          lat;
    logic [31:0] res;
    int          done_cnt;
    run_op(OP_DIVU, 32'd1000, 32'd3, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'd333) begin
      errors++;
      $display("FAIL divu_1000_3 latency=%0d result=%h expected 34/0000014d", lat, res);
    end
    dif.div_start = 1'b1;
    dif.div_op    = OP_DIVU;
    dif.div_a     = 32'd100;
    dif.div_b     = 32'd7;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    dif.div_kill = 1'b1;
    @(posedge clk); #1;
    dif.div_kill = 1'b0;
    checks++;
    if (dif.div_busy !== 1'b0 || dif.div_done !== 1'b0 || dif.div_result !== 32'd333) begin
      errors++;
      $display("FAIL kill_e10 busy=%b done=%b result=%h expected 0/0/0000014d",
               dif.div_busy, dif.div_done, dif.div_result);
    end
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.div_done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || dif.div_result !== 32'd333) begin
      errors++;
      $display("FAIL kill_no_done dones=%0d result=%h expected 0/0000014d", done_cnt, dif.div_result);
    end
  endtask

  task automatic test_start_while_busy();
    int done_cnt;
    int lat;
    dif.div_start = 1'b1;
    dif.div_op    = OP_DIVU;
    dif.div_a     = 32'd100;
    dif.div_b     = 32'd7;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    dif.div_start = 1'b1;
    dif.div_op    = OP_DIV;
    dif.div_a     = 32'd5;
    dif.div_b     = 32'd0;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    lat = -1;
    for (int i = 5; i <= 60; i++) begin
      @(posedge clk); #1;
      if (dif.div_done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 34 || dif.div_result !== 32'd14) begin
      errors++;
      $display("FAIL start_while_busy latency=%0d result=%h expected 34/0000000e", lat, dif.div_result);
    end
    done_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (dif.div_done || dif.div_busy) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL ignored_start_leftover active_cycles=%0d expected 0", done_cnt);
    end
    // Start together with kill in IDLE is refused.
    dif.div_start = 1'b1;
    dif.div_kill  = 1'b1;
    dif.div_op    = OP_DIVU;
    dif.div_a     = 32'd9;
    dif.div_b     = 32'd0;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    dif.div_kill  = 1'b0;
    done_cnt = 0;
    if (dif.div_busy) done_cnt++;
    repeat (4) begin
      @(posedge clk); #1;
      if (dif.div_done || dif.div_busy) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || dif.div_result !== 32'd14) begin
      errors++;
      $display("FAIL start_with_kill active_cycles=%0d result=%h expected 0/0000000e", done_cnt, dif.div_result);
    end
  endtask

  task automatic test_cache();
    int          lat;
    logic [31:0] res;
    run_op(OP_DIV, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'd14) begin
      errors++;
      $display("FAIL cache_fill_div latency=%0d result=%h expected 34/0000000e", lat, res);
    end
    run_op(OP_REM, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== HIT_LAT || res !== 32'd2) begin
      errors++;
      $display("FAIL cache_rem latency=%0d result=%h expected %0d/00000002", lat, res, HIT_LAT);
    end
    checks++;
    if (dif.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL cache_busy_at_done busy=%b expected 0", dif.div_busy);
    end
    dif.div_kill = 1'b1;
    @(posedge clk); #1;
    dif.div_kill = 1'b0;
    run_op(OP_REM, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 34 || res !== 32'd2) begin
      errors++;
      $display("FAIL cache_after_kill latency=%0d result=%h expected 34/00000002", lat, res);
    end
  endtask

  task automatic test_reset_midop();
    int done_cnt;
    dif.div_start = 1'b1;
    dif.div_op    = OP_DIVU;
    dif.div_a     = 32'd55;
    dif.div_b     = 32'd5;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dif.div_busy !== 1'b0 || dif.div_done !== 1'b0 || dif.div_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_midop busy=%b done=%b result=%h expected 0/0/00000000",
               dif.div_busy, dif.div_done, dif.div_result);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.div_done || dif.div_busy) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || dif.div_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_midop_quiet active_cycles=%0d result=%h expected 0/00000000",
               done_cnt, dif.div_result);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    dif.div_start = 1'b0;
    dif.div_op    = 2'b00;
    dif.div_a     = 32'h0;
    dif.div_b     = 32'h0;
    dif.div_kill  = 1'b0;
    test_reset();
    test_divu();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_kill();
    test_start_while_busy();
    test_cache();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
